// File: rtl/score_bcd_engine_if.sv
// Handshake/bus bundle for the BCD score engine: game-event inputs and score/status outputs.
interface score_bcd_engine_if #(
  parameter int unsigned DIGITS    = 4,
  parameter int unsigned N_ENM     = 4,
  parameter int unsigned ENM_HP_W  = 7,
  parameter int unsigned BOSS_HP_W = 10
);
  logic                        shot_reimu;
  logic                        shot_enm;
  logic                        shot_boss;
  logic [N_ENM*ENM_HP_W-1:0]   enmhp;
  logic [BOSS_HP_W-1:0]        bosshp;
  logic [4*DIGITS-1:0]         score;
  logic [4*DIGITS-1:0]         hiscore;
  logic                        busy;
  logic                        ovf;
  logic                        lost;

  modport master (
    output shot_reimu, shot_enm, shot_boss, enmhp, bosshp,
    input  score, hiscore, busy, ovf, lost
  );

  modport slave (
    input  shot_reimu, shot_enm, shot_boss, enmhp, bosshp,
    output score, hiscore, busy, ovf, lost
  );
endinterface

// File: rtl/score_bcd_engine.sv
// BCD score accumulator: per-class saturating event queues drained by a digit-serial
// carry-ripple adder, with high-score tracking, saturation at all 9s and clear on player hit.
module score_bcd_engine #(
  parameter int unsigned DIGITS     = 4,
  parameter int unsigned N_ENM      = 4,
  parameter int unsigned ENM_HP_W   = 7,
  parameter int unsigned BOSS_HP_W  = 10,
  parameter int unsigned PEND_W     = 4,
  parameter int unsigned KILL_DIGIT = 2,
  parameter int unsigned BOSS_DIGIT = 3
) (
  input  logic              clk22,
  input  logic              rst,
  score_bcd_engine_if.slave bus_if
);
  localparam int unsigned SCORE_W = 4 * DIGITS;
  localparam int unsigned IDX_W   = $clog2(DIGITS);
  localparam int unsigned SEL_W   = $clog2(SCORE_W);
  localparam int unsigned KCNT_W  = $clog2(N_ENM + 1);
  localparam int unsigned SUM_W   = PEND_W + KCNT_W + 1;
  localparam int unsigned N_CLS   = 4;
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  // Class slots in the pending array; higher index wins arbitration.
  localparam int unsigned C_HIT_E  = 0;
  localparam int unsigned C_HIT_B  = 1;
  localparam int unsigned C_KILL_E = 2;
  localparam int unsigned C_KILL_B = 3;

  typedef enum logic [1:0] {S_IDLE, S_ADD, S_CLEAR} state_e;

  state_e                        state_q, state_d;
  logic [SCORE_W-1:0]            score_q, score_d;
  logic [SCORE_W-1:0]            hiscore_q, hiscore_d;
  logic [N_CLS-1:0][PEND_W-1:0]  pend_q, pend_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic [1:0]                    addend_q, addend_d;
  logic                          carry_q, carry_d;
  logic                          clear_req_q, clear_req_d;
  logic                          ovf_q, ovf_d;
  logic                          lost_q, lost_d;
  logic                          busy_q, busy_d;
  logic [N_ENM-1:0]              enm_dead_q, enm_dead_d;
  logic                          boss_dead_q, boss_dead_d;

  logic [N_CLS-1:0][KCNT_W-1:0]  inc;
  logic [KCNT_W-1:0]             kill_e_cnt;
  logic [N_CLS-1:0]              deq;
  logic                          flush;
  logic [SEL_W-1:0]              sel;
  logic [3:0]                    digit;
  logic [4:0]                    dsum;
  logic [SUM_W-1:0]              psum;

  // Event sampling: hits are level-per-cycle, kills are HP reaching 0 while not yet dead.
  always_comb begin
    kill_e_cnt = '0;
    enm_dead_d = '0;
    for (int i = 0; i < N_ENM; i++) begin
      enm_dead_d[i] = (bus_if.enmhp[i*ENM_HP_W +: ENM_HP_W] == '0);
      if (enm_dead_d[i] && !enm_dead_q[i]) kill_e_cnt = kill_e_cnt + KCNT_W'(1);
    end
    boss_dead_d     = (bus_if.bosshp == '0);
    inc[C_HIT_E]    = KCNT_W'(bus_if.shot_enm);
    inc[C_HIT_B]    = KCNT_W'(bus_if.shot_boss);
    inc[C_KILL_E]   = kill_e_cnt;
    inc[C_KILL_B]   = KCNT_W'(boss_dead_d && !boss_dead_q);
  end

  // FSM next-state, digit-serial BCD add and pending-queue update.
  always_comb begin
    state_d     = state_q;
    score_d     = score_q;
    idx_d       = idx_q;
    addend_d    = addend_q;
    carry_d     = carry_q;
    ovf_d       = ovf_q;
    lost_d      = lost_q;
    clear_req_d = clear_req_q | bus_if.shot_reimu;
    pend_d      = pend_q;
    deq         = '0;
    flush       = 1'b0;
    psum        = '0;
    sel         = SEL_W'({idx_q, 2'b00});
    digit       = score_q[sel +: 4];
    dsum        = 5'(digit) + 5'(addend_q) + 5'(carry_q);

    case (state_q)
      S_IDLE: begin
        if (clear_req_q) begin
          state_d = S_CLEAR;
        end else if (pend_q[C_KILL_B] != '0) begin
          deq[C_KILL_B] = 1'b1;
          idx_d         = IDX_W'(BOSS_DIGIT);
          addend_d      = 2'd1;
          carry_d       = 1'b0;
          state_d       = S_ADD;
        end else if (pend_q[C_KILL_E] != '0) begin
          deq[C_KILL_E] = 1'b1;
          idx_d         = IDX_W'(KILL_DIGIT);
          addend_d      = 2'd1;
          carry_d       = 1'b0;
          state_d       = S_ADD;
        end else if (pend_q[C_HIT_B] != '0) begin
          deq[C_HIT_B]  = 1'b1;
          idx_d         = '0;
          addend_d      = 2'd2;
          carry_d       = 1'b0;
          state_d       = S_ADD;
        end else if (pend_q[C_HIT_E] != '0) begin
          deq[C_HIT_E]  = 1'b1;
          idx_d         = '0;
          addend_d      = 2'd1;
          carry_d       = 1'b0;
          state_d       = S_ADD;
        end
      end
      S_ADD: begin
        if (ovf_q) begin
          // Already pinned at all 9s: the event is consumed without touching the score.
          carry_d = 1'b0;
          state_d = S_IDLE;
        end else if (dsum > 5'd9) begin
          if (idx_q == IDX_W'(DIGITS - 1)) begin
            score_d = {DIGITS{4'h9}};
            ovf_d   = 1'b1;
            carry_d = 1'b0;
            state_d = S_IDLE;
          end else begin
            score_d[sel +: 4] = 4'(dsum - 5'd10);
            carry_d           = 1'b1;
            addend_d          = 2'd0;
            idx_d             = idx_q + IDX_W'(1);
          end
        end else begin
          score_d[sel +: 4] = dsum[3:0];
          carry_d           = 1'b0;
          state_d           = S_IDLE;
        end
      end
      S_CLEAR: begin
        score_d     = '0;
        ovf_d       = 1'b0;
        lost_d      = 1'b0;
        clear_req_d = 1'b0;
        flush       = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    for (int c = 0; c < N_CLS; c++) begin
      psum = SUM_W'(pend_q[c]) + SUM_W'(inc[c]) - SUM_W'(deq[c]);
      if (flush) begin
        pend_d[c] = '0;
      end else if (psum > SUM_W'(PEND_MAX)) begin
        pend_d[c] = PEND_MAX;
        lost_d    = 1'b1;
      end else begin
        pend_d[c] = psum[PEND_W-1:0];
      end
    end

    hiscore_d = (score_q > hiscore_q) ? score_q : hiscore_q;
    busy_d    = (state_d != S_IDLE) || (pend_d != '0) || clear_req_d;
  end

  always_ff @(posedge clk22 or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      score_q     <= '0;
      hiscore_q   <= '0;
      pend_q      <= '0;
      idx_q       <= '0;
      addend_q    <= '0;
      carry_q     <= 1'b0;
      clear_req_q <= 1'b0;
      ovf_q       <= 1'b0;
      lost_q      <= 1'b0;
      busy_q      <= 1'b0;
      enm_dead_q  <= '1;
      boss_dead_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      score_q     <= score_d;
      hiscore_q   <= hiscore_d;
      pend_q      <= pend_d;
      idx_q       <= idx_d;
      addend_q    <= addend_d;
      carry_q     <= carry_d;
      clear_req_q <= clear_req_d;
      ovf_q       <= ovf_d;
      lost_q      <= lost_d;
      busy_q      <= busy_d;
      enm_dead_q  <= enm_dead_d;
      boss_dead_q <= boss_dead_d;
    end
  end

  assign bus_if.score   = score_q;
  assign bus_if.hiscore = hiscore_q;
  assign bus_if.busy    = busy_q;
  assign bus_if.ovf     = ovf_q;
  assign bus_if.lost    = lost_q;
endmodule

// File: tb/tb_score_bcd_engine.sv
// Directed bench for score_bcd_engine: latency, ripple carry, kill priority, saturation,
// clear-during-add, queue overflow and asynchronous reset.
module tb_score_bcd_engine;
  localparam int unsigned DIGITS    = 4;
  localparam int unsigned N_ENM     = 4;
  localparam int unsigned ENM_HP_W  = 7;
  localparam int unsigned BOSS_HP_W = 10;

  logic clk22 = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk22 = ~clk22;

  score_bcd_engine_if #(.DIGITS(DIGITS), .N_ENM(N_ENM), .ENM_HP_W(ENM_HP_W),
                        .BOSS_HP_W(BOSS_HP_W)) bus_if ();

  score_bcd_engine #(.DIGITS(DIGITS), .N_ENM(N_ENM), .ENM_HP_W(ENM_HP_W),
                     .BOSS_HP_W(BOSS_HP_W), .PEND_W(4), .KILL_DIGIT(2),
                     .BOSS_DIGIT(3)) dut (
    .clk22  (clk22),
    .rst    (rst),
    .bus_if (bus_if.slave)
  );

  task automatic tick();
    @(negedge clk22);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input string tag, input int max_cyc);
    int n = 0;
    do begin
      tick();
      n++;
    end while (bus_if.busy !== 1'b0 && n < max_cyc);
    chk(tag, 32'(bus_if.busy), 32'd0);
  endtask

  task automatic hit_enm();
    bus_if.shot_enm = 1'b1;
    tick();
    bus_if.shot_enm = 1'b0;
    wait_idle("hit_enm_idle", 20);
  endtask

  task automatic hit_boss();
    bus_if.shot_boss = 1'b1;
    tick();
    bus_if.shot_boss = 1'b0;
    wait_idle("hit_boss_idle", 20);
  endtask

  task automatic kill_boss();
    bus_if.bosshp = '0;
    tick();
    bus_if.bosshp = 10'd100;
    tick();
    wait_idle("kill_boss_idle", 20);
  endtask

  task automatic kill_enm0();
    bus_if.enmhp[0 +: ENM_HP_W] = '0;
    tick();
    bus_if.enmhp[0 +: ENM_HP_W] = 7'd10;
    tick();
    wait_idle("kill_enm0_idle", 20);
  endtask

  initial begin
    rst               = 1'b1;
    bus_if.shot_reimu = 1'b0;
    bus_if.shot_enm   = 1'b0;
    bus_if.shot_boss  = 1'b0;
    bus_if.enmhp      = '0;
    bus_if.bosshp     = '0;
    tick();
    tick();
    chk("rst_score",   32'(bus_if.score),   32'h0);
    chk("rst_hiscore", 32'(bus_if.hiscore), 32'h0);
    chk("rst_busy",    32'(bus_if.busy),    32'd0);
    chk("rst_ovf",     32'(bus_if.ovf),     32'd0);
    chk("rst_lost",    32'(bus_if.lost),    32'd0);
    rst = 1'b0;

    // HP already 0 out of reset never scores.
    repeat (3) tick();
    chk("hp0_no_kill_score", 32'(bus_if.score), 32'h0);
    chk("hp0_no_kill_busy",  32'(bus_if.busy),  32'd0);
    bus_if.enmhp  = {4{7'd10}};
    bus_if.bosshp = 10'd100;
    tick();

    // 1: single enemy hit, latency and hiscore lag.
    bus_if.shot_enm = 1'b1;
    tick();
    bus_if.shot_enm = 1'b0;
    chk("t1_busy_e1",  32'(bus_if.busy),  32'd1);
    chk("t1_score_e1", 32'(bus_if.score), 32'h0);
    tick();
    chk("t1_score_e2", 32'(bus_if.score), 32'h0);
    tick();
    chk("t1_score_e3",   32'(bus_if.score),   32'h0001);
    chk("t1_busy_e3",    32'(bus_if.busy),    32'd0);
    chk("t1_hiscore_e3", 32'(bus_if.hiscore), 32'h0);
    tick();
    chk("t1_hiscore_e4", 32'(bus_if.hiscore), 32'h0001);

    // 2: 0099 + 2 ripples through d0 -> d1 -> d2.
    for (int i = 0; i < 49; i++) hit_boss();
    chk("t2_pre", 32'(bus_if.score), 32'h0099);
    bus_if.shot_boss = 1'b1;
    tick();
    bus_if.shot_boss = 1'b0;
    tick();
    tick();
    chk("t2_d0_written", 32'(bus_if.score), 32'h0091);
    tick();
    chk("t2_d1_written", 32'(bus_if.score), 32'h0001);
    tick();
    chk("t2_final", 32'(bus_if.score), 32'h0101);
    chk("t2_busy",  32'(bus_if.busy),  32'd0);
    chk("t2_ovf",   32'(bus_if.ovf),   32'd0);

    // 3: two simultaneous kills plus both hits; kills go first.
    bus_if.enmhp[1*ENM_HP_W +: ENM_HP_W] = '0;
    bus_if.enmhp[3*ENM_HP_W +: ENM_HP_W] = '0;
    bus_if.shot_enm  = 1'b1;
    bus_if.shot_boss = 1'b1;
    tick();
    bus_if.shot_enm  = 1'b0;
    bus_if.shot_boss = 1'b0;
    tick();
    tick();
    chk("t3_first_kill", 32'(bus_if.score), 32'h0201);
    wait_idle("t3_idle", 30);
    chk("t3_total", 32'(bus_if.score), 32'h0304);

    // 4: build up to 9999, then saturate and clear.
    for (int i = 0; i < 9; i++) kill_boss();
    chk("t4_boss_kills", 32'(bus_if.score), 32'h9304);
    for (int i = 0; i < 6; i++) kill_enm0();
    chk("t4_enm_kills", 32'(bus_if.score), 32'h9904);
    for (int i = 0; i < 47; i++) hit_boss();
    hit_enm();
    chk("t4_9999",     32'(bus_if.score), 32'h9999);
    chk("t4_ovf_pre",  32'(bus_if.ovf),   32'd0);
    hit_enm();
    chk("t4_sat_score", 32'(bus_if.score), 32'h9999);
    chk("t4_sat_ovf",   32'(bus_if.ovf),   32'd1);
    hit_boss();
    chk("t4_sat_hold", 32'(bus_if.score),   32'h9999);
    chk("t4_hiscore",  32'(bus_if.hiscore), 32'h9999);
    bus_if.shot_reimu = 1'b1;
    tick();
    bus_if.shot_reimu = 1'b0;
    chk("t4_clr_busy", 32'(bus_if.busy), 32'd1);
    tick();
    chk("t4_clr_pending", 32'(bus_if.score), 32'h9999);
    tick();
    chk("t4_clr_score",   32'(bus_if.score),   32'h0);
    chk("t4_clr_ovf",     32'(bus_if.ovf),     32'd0);
    chk("t4_clr_hiscore", 32'(bus_if.hiscore), 32'h9999);
    chk("t4_clr_busy0",   32'(bus_if.busy),    32'd0);

    // 5: clear requested mid-ripple with 3 enemy hits queued.
    for (int i = 0; i < 4; i++) hit_boss();
    hit_enm();
    chk("t5_pre", 32'(bus_if.score), 32'h0009);
    bus_if.shot_enm  = 1'b1;
    bus_if.shot_boss = 1'b1;
    tick();
    bus_if.shot_boss = 1'b0;
    tick();
    bus_if.shot_reimu = 1'b1;
    tick();
    bus_if.shot_enm   = 1'b0;
    bus_if.shot_reimu = 1'b0;
    chk("t5_mid_ripple", 32'(bus_if.score), 32'h0001);
    tick();
    chk("t5_ripple_done", 32'(bus_if.score), 32'h0011);
    chk("t5_busy",        32'(bus_if.busy),  32'd1);
    tick();
    chk("t5_no_dequeue", 32'(bus_if.score), 32'h0011);
    tick();
    chk("t5_cleared",  32'(bus_if.score), 32'h0);
    chk("t5_idle",     32'(bus_if.busy),  32'd0);
    repeat (4) tick();
    chk("t5_flushed",  32'(bus_if.score),   32'h0);
    chk("t5_hiscore",  32'(bus_if.hiscore), 32'h9999);

    // 6a: 20 consecutive hits fit in the queue while it drains.
    bus_if.shot_enm = 1'b1;
    repeat (20) tick();
    bus_if.shot_enm = 1'b0;
    wait_idle("t6a_idle", 100);
    chk("t6a_score", 32'(bus_if.score), 32'h0020);
    chk("t6a_lost",  32'(bus_if.lost),  32'd0);

    // 6b: 40 consecutive hits overflow the queue from edge 30 on; 6 events dropped.
    bus_if.shot_enm = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (i == 29) chk("t6b_lost_e29", 32'(bus_if.lost), 32'd0);
      if (i == 30) chk("t6b_lost_e30", 32'(bus_if.lost), 32'd1);
    end
    bus_if.shot_enm = 1'b0;
    wait_idle("t6b_idle", 200);
    chk("t6b_score", 32'(bus_if.score), 32'h0054);
    chk("t6b_lost",  32'(bus_if.lost),  32'd1);

    // Asynchronous reset while an add is in flight.
    bus_if.shot_enm = 1'b1;
    tick();
    bus_if.shot_enm = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1;
    chk("arst_score",   32'(bus_if.score),   32'h0);
    chk("arst_hiscore", 32'(bus_if.hiscore), 32'h0);
    chk("arst_busy",    32'(bus_if.busy),    32'd0);
    chk("arst_ovf",     32'(bus_if.ovf),     32'd0);
    chk("arst_lost",    32'(bus_if.lost),    32'd0);
    tick();
    rst = 1'b0;
    repeat (5) tick();
    chk("arst_after_score", 32'(bus_if.score), 32'h0);
    chk("arst_after_busy",  32'(bus_if.busy),  32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
